// File: rtl/div_share_ctrl.sv
// Arbitrates NREQ requesters onto one external combinational divider.
// Zero divisors are answered locally. The divider output is sampled after DIV_LAT cycles.
module div_share_ctrl #(
  parameter int unsigned NREQ    = 3,
  parameter int unsigned W       = 24,
  parameter int unsigned DIV_LAT = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  input  logic [NREQ*W-1:0] req_dividend,
  input  logic [NREQ*W-1:0] req_divisor,
  output logic [W-1:0]    div_dividend,
  output logic [W-1:0]    div_divisor,
  input  logic [W-1:0]    div_quotient,
  input  logic [W-1:0]    div_remainder,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [1:0]      rsp_id,
  output logic [W-1:0]    rsp_quotient,
  output logic [W-1:0]    rsp_remainder,
  output logic            rsp_divzero,
  output logic            busy,
  output logic [7:0]      divzero_cnt
);

  localparam int unsigned PW = 2;
  localparam int unsigned CW = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [PW-1:0]   ptr_q;
  logic [CW-1:0]   cnt_q;
  logic [W-1:0]    op_dividend_q;
  logic [W-1:0]    op_divisor_q;

  logic            gnt_found;
  logic [PW-1:0]   gnt_idx;
  logic [PW-1:0]   scan_idx;
  logic [W-1:0]    sel_dividend;
  logic [W-1:0]    sel_divisor;
  logic            accept;
  logic            zero_op;
  logic            capture;

  // Round-robin scan: first valid requester at or after ptr, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      scan_idx = PW'((32'(ptr_q) + k) % NREQ);
      if (!gnt_found && req_valid[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    sel_dividend = req_dividend[32'(gnt_idx) * W +: W];
    sel_divisor  = req_divisor[32'(gnt_idx) * W +: W];
  end

  // Ready is offered only to the winner and only while idle and out of reset.
  always_comb begin
    req_ready = '0;
    if (rst_n && (state_q == S_IDLE) && gnt_found) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    zero_op = 1'b0;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          accept = 1'b1;
          if (sel_divisor == '0) begin
            zero_op = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operand latch, pointer advance and settle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q         <= '0;
      cnt_q         <= '0;
      op_dividend_q <= '0;
      op_divisor_q  <= '0;
      rsp_id        <= '0;
    end else begin
      if (accept) begin
        op_dividend_q <= sel_dividend;
        op_divisor_q  <= sel_divisor;
        rsp_id        <= gnt_idx;
        ptr_q         <= (gnt_idx == PW'(NREQ - 1)) ? '0 : PW'(gnt_idx + PW'(1));
        if (!zero_op) begin
          cnt_q <= CW'(DIV_LAT - 1);
        end
      end else if ((state_q == S_WAIT) && (cnt_q != '0)) begin
        cnt_q <= CW'(cnt_q - CW'(1));
      end
    end
  end

  // Response capture; a zero divisor bypasses the divider entirely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid     <= 1'b0;
      busy          <= 1'b0;
      rsp_quotient  <= '0;
      rsp_remainder <= '0;
      rsp_divzero   <= 1'b0;
      divzero_cnt   <= '0;
    end else begin
      rsp_valid <= (state_d == S_RESP);
      busy      <= (state_d != S_IDLE);
      if (zero_op) begin
        rsp_quotient  <= '1;
        rsp_remainder <= sel_dividend;
        rsp_divzero   <= 1'b1;
        if (divzero_cnt != 8'hFF) begin
          divzero_cnt <= 8'(divzero_cnt + 8'd1);
        end
      end else if (capture) begin
        rsp_quotient  <= div_quotient;
        rsp_remainder <= div_remainder;
        rsp_divzero   <= 1'b0;
      end
    end
  end

  assign div_dividend = op_dividend_q;
  assign div_divisor  = op_divisor_q;

endmodule

// File: tb/tb_div_share_ctrl.sv
// Scoreboard bench for div_share_ctrl: expected results are queued at issue time
// and compared at each response handshake; response latency is tracked per accept.
module tb_div_share_ctrl;

  localparam int unsigned NREQ    = 3;
  localparam int unsigned W       = 24;
  localparam int unsigned DIV_LAT = 2;

  typedef struct {
    logic [1:0]   id;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_dividend;
  logic [NREQ*W-1:0] req_divisor;
  logic [W-1:0]      div_dividend;
  logic [W-1:0]      div_divisor;
  logic [W-1:0]      div_quotient;
  logic [W-1:0]      div_remainder;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [W-1:0]      rsp_quotient;
  logic [W-1:0]      rsp_remainder;
  logic              rsp_divzero;
  logic              busy;
  logic [7:0]        divzero_cnt;

  div_share_ctrl #(.NREQ(NREQ), .W(W), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
    .rsp_divzero(rsp_divzero), .busy(busy), .divzero_cnt(divzero_cnt)
  );

  // External divider stub; returns junk on a zero divisor so it must be ignored.
  assign div_quotient  = (div_divisor == '0) ? W'(24'h123456) : div_dividend / div_divisor;
  assign div_remainder = (div_divisor == '0) ? W'(24'h654321) : div_dividend % div_divisor;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           n_vec;
  int           n_err;
  int           cyc;
  int           mptr;
  int           mdz;
  logic         prev_valid;
  exp_t         sbq[$];
  int           latq[$];
  logic [W-1:0] opa[NREQ];
  logic [W-1:0] opb[NREQ];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.id = 2'(id);
    if (b == '0) begin
      e.q  = '1;
      e.r  = a;
      e.dz = 1'b1;
    end else begin
      e.q  = a / b;
      e.r  = a % b;
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // One clock: monitor at the falling edge, release accepted requests after the rising edge.
  task automatic tick();
    logic [NREQ-1:0] pend;
    exp_t e;
    @(negedge clk);
    pend = req_valid & req_ready;
    if (rst_n) begin
      for (int i = 0; i < NREQ; i++) begin
        if (pend[i]) latq.push_back(cyc + 1 + ((opb[i] == '0) ? 0 : int'(DIV_LAT)));
      end
      if (rsp_valid && !prev_valid) begin
        if (latq.size() == 0) chk("spurious_rsp", 32'd1, 32'd0);
        else chk("latency", 32'(cyc), 32'(latq.pop_front()));
      end
      if (rsp_valid && rsp_ready) begin
        if (sbq.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("rsp_id", 32'(rsp_id), 32'(e.id));
          chk("rsp_q", 32'(rsp_quotient), 32'(e.q));
          chk("rsp_r", 32'(rsp_remainder), 32'(e.r));
          chk("rsp_dz", 32'(rsp_divzero), 32'(e.dz));
        end
      end
    end
    prev_valid = rsp_valid;
    @(posedge clk);
    #1;
    req_valid = req_valid & ~pend;
    cyc++;
  endtask

  // Drive requests in mask and queue expectations in round-robin grant order.
  task automatic issue(input logic [NREQ-1:0] mask);
    int idx;
    int last;
    last = mptr;
    for (int i = 0; i < NREQ; i++) begin
      if (mask[i]) begin
        req_dividend[i*W +: W] = opa[i];
        req_divisor[i*W +: W]  = opb[i];
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      idx = (mptr + k) % NREQ;
      if (mask[idx]) begin
        sbq.push_back(model(idx, opa[idx], opb[idx]));
        if (opb[idx] == '0 && mdz < 255) mdz++;
        last = idx;
      end
    end
    mptr = (last + 1) % NREQ;
    req_valid = req_valid | mask;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(sbq.size() == 0 && !busy && req_valid == '0) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NREQ-1:0] m;
    logic [W-1:0]    s_q, s_r;
    logic [1:0]      s_id;
    int              n;
    int              r;
    n_vec = 0; n_err = 0; cyc = 0; mptr = 0; mdz = 0; prev_valid = 1'b0;
    rst_n = 1'b0; rsp_ready = 1'b1;
    req_valid = '0; req_dividend = '0; req_divisor = '0;
    for (int i = 0; i < NREQ; i++) begin opa[i] = '0; opb[i] = '0; end

    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_dzcnt", 32'(divzero_cnt), 32'd0);
    chk("rst_opa", 32'(div_dividend), 32'd0);
    chk("rst_q", 32'(rsp_quotient), 32'd0);
    rst_n = 1'b1;
    tick();

    // Simultaneous requests, then pointer moves past a lone requester 1.
    opa[0] = 144;    opb[0] = 12;
    opa[1] = 123456; opb[1] = 789;
    opa[2] = 2023;   opb[2] = 1;
    issue(3'b111);
    #1 chk("first_grant", 32'(req_ready), 32'b001);
    wait_idle();
    opa[1] = 5000; opb[1] = 7;
    issue(3'b010);
    wait_idle();
    opa[0] = 999999; opb[0] = 1000;
    opa[1] = 42;     opb[1] = 43;
    opa[2] = 16777215; opb[2] = 16777215;
    issue(3'b111);
    #1 chk("ptr_wrap_grant", 32'(req_ready), 32'b100);
    wait_idle();

    opa[0] = 100; opb[0] = 3;
    issue(3'b001);
    wait_idle();

    opa[2] = 100; opb[2] = 0;
    issue(3'b100);
    wait_idle();
    chk("dzcnt_one", 32'(divzero_cnt), 32'd1);

    for (int t = 0; t < 10; t++) begin
      m = NREQ'($urandom_range(1, 7));
      for (int i = 0; i < NREQ; i++) begin
        opa[i] = W'($urandom);
        r = int'($urandom_range(0, 4));
        opb[i] = (r == 0) ? '0 : (r == 1) ? W'($urandom) : W'($urandom_range(1, 4095));
      end
      issue(m);
      wait_idle();
    end
    chk("dzcnt_rand", 32'(divzero_cnt), 32'(mdz));

    for (int t = 0; t < 256; t++) begin
      r = int'($urandom_range(0, 2));
      opa[r] = W'($urandom);
      opb[r] = '0;
      issue(NREQ'(1 << r));
      wait_idle();
    end
    chk("dzcnt_sat", 32'(divzero_cnt), 32'd255);

    // Back-pressure: response held, other requesters kept off.
    rsp_ready = 1'b0;
    opa[0] = 500; opb[0] = 7;
    issue(3'b001);
    n = 0;
    while (!rsp_valid && n < 50) begin tick(); n++; end
    chk("stall_reach", 32'(rsp_valid), 32'd1);
    s_q = rsp_quotient; s_r = rsp_remainder; s_id = rsp_id;
    opa[1] = 81; opb[1] = 9;
    opa[2] = 17; opb[2] = 0;
    issue(3'b110);
    for (int t = 0; t < 5; t++) begin
      tick();
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_q", 32'(rsp_quotient), 32'(s_q));
      chk("hold_r", 32'(rsp_remainder), 32'(s_r));
      chk("hold_id", 32'(rsp_id), 32'(s_id));
      chk("hold_ready", 32'(req_ready), 32'd0);
      chk("hold_opa", 32'(div_dividend), 32'd500);
    end
    rsp_ready = 1'b1;
    tick();
    chk("resume_busy", 32'(busy), 32'd0);
    chk("resume_grant", 32'(req_ready), 32'b010);
    wait_idle();

    // Reset while an operation waits on the divider.
    opa[2] = 77; opb[2] = 5;
    issue(3'b100);
    tick();
    chk("wait_busy", 32'(busy), 32'd1);
    chk("wait_valid", 32'(rsp_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst2_busy", 32'(busy), 32'd0);
    chk("rst2_valid", 32'(rsp_valid), 32'd0);
    chk("rst2_opa", 32'(div_dividend), 32'd0);
    chk("rst2_opb", 32'(div_divisor), 32'd0);
    chk("rst2_id", 32'(rsp_id), 32'd0);
    chk("rst2_dzcnt", 32'(divzero_cnt), 32'd0);
    chk("rst2_ready", 32'(req_ready), 32'd0);
    sbq.delete(); latq.delete();
    mptr = 0; mdz = 0; prev_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    repeat (6) tick();
    opa[1] = 900; opb[1] = 30;
    issue(3'b010);
    #1 chk("post_rst_grant", 32'(req_ready), 32'b010);
    wait_idle();
    opa[0] = 65536; opb[0] = 255;
    opa[2] = 12;    opb[2] = 0;
    issue(3'b101);
    wait_idle();
    chk("post_rst_dzcnt", 32'(divzero_cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
